repair_rx: RTL and testbench
============================

# repair_rx

Partner-side responder for the MBTRAIN REPAIR sub-state. It sits directly downstream of the local REPAIR requester across the sideband. It consumes the requester's INIT, APPLY_DEGRADE and END requests, latches the lane-degrade encoding carried with APPLY_DEGRADE, and returns the matching responses. It then reports completion, the applied lane map and any error or timeout to MBTRAIN.

## Interface
Parameters:
- TIMEOUT_CYCLES, 8000: maximum cycles spent in any WAIT state before the block aborts.
- CNT_W, 13: width of the timeout counter; 2^CNT_W must be at least TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  enable from MBTRAIN; low forces IDLE on the next edge.
- i_sideband_message  in  4  decoded incoming sideband message.
- i_sideband_valid  in  1  qualifies i_sideband_message for one cycle.
- i_sideband_data_lanes_encoding  in  3  lane map received with APPLY_DEGRADE_REQUEST.
- i_busy_negedge_detected  in  1  the sideband serializer has finished a transmission.
- i_valid_tx  in  1  the local requester is currently driving the sideband.
- o_sideband_message  out  4  response message code.
- o_valid_rx  out  1  response pending on the sideband.
- o_lanes_result  out  3  applied lane map: 011 = all lanes, 001 = lanes 0-7, 010 = lanes 8-15.
- o_degrade_error  out  1  the received encoding was outside {001, 010, 011}.
- o_timeout  out  1  a WAIT state expired.
- o_test_ack  out  1  the REPAIR partner flow is complete.

Message codes: INIT_REQUEST 0001, INIT_RESPONSE 0010, END_REQUEST 0101, END_RESPONSE 0110, APPLY_DEGRADE_REQUEST 0111, APPLY_DEGRADE_RESPONSE 1000.

## Operation
- States:
  - IDLE
  - WAIT_INIT_REQ
  - WAIT_DEGRADE_REQ
  - WAIT_END_REQ
  - END_RESP_SENT
  - TEST_FINISH
- Transitions:
  - IDLE -> WAIT_INIT_REQ when i_en = 1.
  - WAIT_INIT_REQ -> WAIT_DEGRADE_REQ on INIT_REQUEST with valid. Response: INIT_RESPONSE.
  - WAIT_DEGRADE_REQ -> WAIT_END_REQ on APPLY_DEGRADE_REQUEST with valid. Response: APPLY_DEGRADE_RESPONSE. The block latches the encoding:
    - If the encoding is 001, 010 or 011, o_lanes_result takes that value.
    - Otherwise o_lanes_result becomes 000 and o_degrade_error is set. The response is still sent.
  - WAIT_END_REQ -> END_RESP_SENT on END_REQUEST with valid. Response: END_RESPONSE.
  - END_RESP_SENT -> TEST_FINISH on the cycle o_valid_rx clears. o_test_ack is set on that same edge.
  - TEST_FINISH holds until i_en = 0.
- A valid message that does not match the current WAIT state is ignored: no state change and no response.
- o_valid_rx set/clear:
  - Set on every response edge.
  - Cleared when i_busy_negedge_detected = 1 and i_valid_tx = 0.
  - If set and clear occur in the same cycle, set wins.
- Timeout:
  - The counter clears on every state change and increments each cycle in the WAIT states.
  - When it reaches TIMEOUT_CYCLES-1, the next edge moves to TEST_FINISH with o_timeout = 1, o_test_ack = 1 and o_valid_rx = 0.
- o_degrade_error, o_timeout and o_lanes_result hold until IDLE is re-entered.
- IDLE clears all outputs and the counter.

## Timing
- Reset (rst = 1 at an edge): state IDLE; every output is 0; counter is 0.
- i_en = 0 at an edge: same effect as reset. This takes priority over any simultaneous valid message or timeout.
- Response latency: o_sideband_message and o_valid_rx update on the edge after the request cycle (1 cycle).
- o_test_ack:
  - Rises one edge after o_valid_rx falls in END_RESP_SENT.
  - On timeout, rises on the expiry edge.
- Earliest full flow: enable at edge 0, requests at cycles 1, 3 and 5, with i_busy_negedge_detected 1 cycle after each response. This gives o_test_ack = 1 at edge 8.
- Simultaneous timeout expiry and a matching request: the request wins and the counter clears.
- A request arriving while o_valid_rx is still 1 from a previous response: the message is overwritten and o_valid_rx stays 1.

## Test plan
- Nominal flow with encoding 011: send INIT_REQUEST, APPLY_DEGRADE_REQUEST and END_REQUEST, each followed by a busy negedge. Required: responses 0010, 1000 and 0110, each 1 cycle after its request; o_lanes_result = 011; o_test_ack = 1 one cycle after the final o_valid_rx fall; o_degrade_error = 0.
- Encoding 010 and then encoding 000 in separate runs. Required: o_lanes_result = 010 in the first run. In the second, o_lanes_result = 000, o_degrade_error = 1 and APPLY_DEGRADE_RESPONSE is still sent.
- Out-of-order: END_REQUEST in WAIT_INIT_REQ. Required: state unchanged, o_valid_rx stays 0, o_sideband_message stays 0000.
- Timeout with TIMEOUT_CYCLES = 16 and no request after enable. Required: o_timeout = 1 and o_test_ack = 1 at edge 17; o_valid_rx = 0.
- i_en drops in WAIT_END_REQ with o_valid_rx = 1. Required: next edge gives IDLE with all outputs 0. Re-enable gives a clean restart.
- Busy negedge while i_valid_tx = 1. Required: o_valid_rx stays 1 until a negedge arrives with i_valid_tx = 0. Also apply a synchronous rst mid-flow and check all outputs are 0 on the next edge.

Source files
------------

// File: rtl/repair_rx.sv
// MBTRAIN REPAIR partner-side responder: answers INIT / APPLY_DEGRADE / END
// sideband requests, latches the degrade lane map and reports completion.
module repair_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 8000,
  parameter int unsigned CNT_W          = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_sideband_message,
  input  logic       i_sideband_valid,
  input  logic [2:0] i_sideband_data_lanes_encoding,
  input  logic       i_busy_negedge_detected,
  input  logic       i_valid_tx,
  output logic [3:0] o_sideband_message,
  output logic       o_valid_rx,
  output logic [2:0] o_lanes_result,
  output logic       o_degrade_error,
  output logic       o_timeout,
  output logic       o_test_ack
);

  localparam logic [3:0] INIT_REQUEST           = 4'b0001;
  localparam logic [3:0] INIT_RESPONSE          = 4'b0010;
  localparam logic [3:0] END_REQUEST            = 4'b0101;
  localparam logic [3:0] END_RESPONSE           = 4'b0110;
  localparam logic [3:0] APPLY_DEGRADE_REQUEST  = 4'b0111;
  localparam logic [3:0] APPLY_DEGRADE_RESPONSE = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT_REQ,
    WAIT_DEGRADE_REQ,
    WAIT_END_REQ,
    END_RESP_SENT,
    TEST_FINISH
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       msg_n;
  logic             valid_rx_n;
  logic [2:0]       lanes_n;
  logic             degrade_error_n;
  logic             timeout_n;
  logic             test_ack_n;
  logic             in_wait;
  logic             expired;

  assign in_wait = (state == WAIT_INIT_REQ) || (state == WAIT_DEGRADE_REQ) ||
                   (state == WAIT_END_REQ);
  assign expired = in_wait && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      o_sideband_message <= '0;
      o_valid_rx         <= 1'b0;
      o_lanes_result     <= '0;
      o_degrade_error    <= 1'b0;
      o_timeout          <= 1'b0;
      o_test_ack         <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      o_sideband_message <= msg_n;
      o_valid_rx         <= valid_rx_n;
      o_lanes_result     <= lanes_n;
      o_degrade_error    <= degrade_error_n;
      o_timeout          <= timeout_n;
      o_test_ack         <= test_ack_n;
    end
  end

  // Priority: disable, then a matching request, then timeout expiry.
  always_comb begin
    state_n         = state;
    msg_n           = o_sideband_message;
    valid_rx_n      = o_valid_rx;
    lanes_n         = o_lanes_result;
    degrade_error_n = o_degrade_error;
    timeout_n       = o_timeout;
    test_ack_n      = o_test_ack;

    if (i_busy_negedge_detected && !i_valid_tx) begin
      valid_rx_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (i_en) begin
          state_n = WAIT_INIT_REQ;
        end
      end
      WAIT_INIT_REQ: begin
        if (i_sideband_valid && (i_sideband_message == INIT_REQUEST)) begin
          state_n    = WAIT_DEGRADE_REQ;
          msg_n      = INIT_RESPONSE;
          valid_rx_n = 1'b1;
        end
      end
      WAIT_DEGRADE_REQ: begin
        if (i_sideband_valid && (i_sideband_message == APPLY_DEGRADE_REQUEST)) begin
          state_n    = WAIT_END_REQ;
          msg_n      = APPLY_DEGRADE_RESPONSE;
          valid_rx_n = 1'b1;
          if ((i_sideband_data_lanes_encoding == 3'b001) ||
              (i_sideband_data_lanes_encoding == 3'b010) ||
              (i_sideband_data_lanes_encoding == 3'b011)) begin
            lanes_n = i_sideband_data_lanes_encoding;
          end else begin
            lanes_n         = 3'b000;
            degrade_error_n = 1'b1;
          end
        end
      end
      WAIT_END_REQ: begin
        if (i_sideband_valid && (i_sideband_message == END_REQUEST)) begin
          state_n    = END_RESP_SENT;
          msg_n      = END_RESPONSE;
          valid_rx_n = 1'b1;
        end
      end
      END_RESP_SENT: begin
        if (!o_valid_rx) begin
          state_n    = TEST_FINISH;
          test_ack_n = 1'b1;
        end
      end
      TEST_FINISH: begin
        state_n = TEST_FINISH;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (expired && (state_n == state)) begin
      state_n    = TEST_FINISH;
      timeout_n  = 1'b1;
      test_ack_n = 1'b1;
      valid_rx_n = 1'b0;
    end

    if (!i_en || (state == IDLE)) begin
      if (!i_en) begin
        state_n = IDLE;
      end
      msg_n           = '0;
      valid_rx_n      = 1'b0;
      lanes_n         = '0;
      degrade_error_n = 1'b0;
      timeout_n       = 1'b0;
      test_ack_n      = 1'b0;
    end

    if (state_n != state) begin
      cnt_n = '0;
    end else if (in_wait) begin
      cnt_n = cnt + CNT_W'(1);
    end else begin
      cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_repair_rx.sv
// Directed bench for repair_rx: nominal flows, degrade encodings, ordering,
// timeout, disable, busy qualification and mid-flow reset.
module tb_repair_rx;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_en;
  logic [3:0] i_sideband_message;
  logic       i_sideband_valid;
  logic [2:0] i_sideband_data_lanes_encoding;
  logic       i_busy_negedge_detected;
  logic       i_valid_tx;
  logic [3:0] o_sideband_message;
  logic       o_valid_rx;
  logic [2:0] o_lanes_result;
  logic       o_degrade_error;
  logic       o_timeout;
  logic       o_test_ack;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  repair_rx #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .i_en                           (i_en),
    .i_sideband_message             (i_sideband_message),
    .i_sideband_valid               (i_sideband_valid),
    .i_sideband_data_lanes_encoding (i_sideband_data_lanes_encoding),
    .i_busy_negedge_detected        (i_busy_negedge_detected),
    .i_valid_tx                     (i_valid_tx),
    .o_sideband_message             (o_sideband_message),
    .o_valid_rx                     (o_valid_rx),
    .o_lanes_result                 (o_lanes_result),
    .o_degrade_error                (o_degrade_error),
    .o_timeout                      (o_timeout),
    .o_test_ack                     (o_test_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] msg, input logic vrx,
                            input logic [2:0] lanes, input logic err, input logic tmo,
                            input logic ack);
    check({tag, ".msg"},   {4'h0, o_sideband_message}, {4'h0, msg});
    check({tag, ".vrx"},   {7'h0, o_valid_rx},         {7'h0, vrx});
    check({tag, ".lanes"}, {5'h0, o_lanes_result},     {5'h0, lanes});
    check({tag, ".err"},   {7'h0, o_degrade_error},    {7'h0, err});
    check({tag, ".tmo"},   {7'h0, o_timeout},          {7'h0, tmo});
    check({tag, ".ack"},   {7'h0, o_test_ack},         {7'h0, ack});
  endtask

  task automatic send(input logic [3:0] msg, input logic [2:0] enc);
    i_sideband_message             = msg;
    i_sideband_data_lanes_encoding = enc;
    i_sideband_valid               = 1'b1;
    step();
    i_sideband_valid   = 1'b0;
    i_sideband_message = 4'h0;
  endtask

  task automatic busy(input logic vtx);
    i_busy_negedge_detected = 1'b1;
    i_valid_tx              = vtx;
    step();
    i_busy_negedge_detected = 1'b0;
    i_valid_tx              = 1'b0;
  endtask

  task automatic restart();
    i_en = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    i_en = 1'b1;
    step();
  endtask

  task automatic run_flow(input logic [2:0] enc, input logic [2:0] lanes, input logic err);
    restart();
    check_outs("flow.enter", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 3'b000);
    check_outs("flow.init_rsp", 4'b0010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    busy(1'b0);
    check("flow.init_clr", {7'h0, o_valid_rx}, 8'h0);
    send(4'b0111, enc);
    check_outs("flow.deg_rsp", 4'b1000, 1'b1, lanes, err, 1'b0, 1'b0);
    busy(1'b0);
    check("flow.deg_clr", {7'h0, o_valid_rx}, 8'h0);
    send(4'b0101, 3'b000);
    check_outs("flow.end_rsp", 4'b0110, 1'b1, lanes, err, 1'b0, 1'b0);
    busy(1'b0);
    check_outs("flow.end_clr", 4'b0110, 1'b0, lanes, err, 1'b0, 1'b0);
    step();
    check_outs("flow.ack", 4'b0110, 1'b0, lanes, err, 1'b0, 1'b1);
    step();
    step();
    check_outs("flow.hold", 4'b0110, 1'b0, lanes, err, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    i_en = 1'b0;
    i_sideband_message = 4'h0;
    i_sideband_valid = 1'b0;
    i_sideband_data_lanes_encoding = 3'b000;
    i_busy_negedge_detected = 1'b0;
    i_valid_tx = 1'b0;
    step();
    step();
    check_outs("reset", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    run_flow(3'b011, 3'b011, 1'b0);
    run_flow(3'b010, 3'b010, 1'b0);
    run_flow(3'b000, 3'b000, 1'b1);
    run_flow(3'b001, 3'b001, 1'b0);
    run_flow(3'b111, 3'b000, 1'b1);

    // Out-of-order END in WAIT_INIT_REQ is ignored; INIT still accepted after.
    restart();
    send(4'b0101, 3'b000);
    check_outs("ooo.end", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    send(4'b0111, 3'b011);
    check_outs("ooo.deg", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 3'b000);
    check_outs("ooo.init", 4'b0010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);

    // Timeout in WAIT_INIT_REQ: 16 edges after entering the state.
    restart();
    for (int i = 0; i < 15; i++) step();
    check_outs("tmo.before", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("tmo.expire", 4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    step();
    check_outs("tmo.hold", 4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);

    // Timeout in WAIT_DEGRADE_REQ with a response still pending forces o_valid_rx low.
    restart();
    send(4'b0001, 3'b000);
    for (int i = 0; i < 15; i++) step();
    check_outs("tmo2.before", 4'b0010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("tmo2.expire", 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);

    // Request on the expiry edge wins and restarts the count.
    restart();
    for (int i = 0; i < 15; i++) step();
    send(4'b0001, 3'b000);
    check_outs("race.req", 4'b0010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    check("race.no_tmo", {7'h0, o_timeout}, 8'h0);
    step();
    check_outs("race.tmo", 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);

    // Disable in WAIT_END_REQ with a pending response, alongside a valid END.
    restart();
    send(4'b0001, 3'b000);
    busy(1'b0);
    send(4'b0111, 3'b011);
    i_en = 1'b0;
    send(4'b0101, 3'b000);
    check_outs("dis.idle", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    i_en = 1'b1;
    step();
    check_outs("dis.reen", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 3'b000);
    check_outs("dis.init", 4'b0010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);

    // Busy negedge while the requester drives the sideband does not clear.
    busy(1'b1);
    check("vtx.hold", {7'h0, o_valid_rx}, 8'h1);
    busy(1'b0);
    check("vtx.clear", {7'h0, o_valid_rx}, 8'h0);

    // Set wins over clear: new request with a simultaneous busy negedge.
    send(4'b0111, 3'b010);
    check("setwin.vrx", {7'h0, o_valid_rx}, 8'h1);
    i_busy_negedge_detected = 1'b1;
    send(4'b0101, 3'b000);
    i_busy_negedge_detected = 1'b0;
    check_outs("setwin.end", 4'b0110, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);

    // Synchronous reset mid-flow.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("midrst", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
